flash_rate_ctrl: RTL and testbench
==================================

// Module: flash_rate_ctrl
// PURPOSE
//   Timebase and LED sequencer driven by the lab3 master FSM's state code and rate-shift pulses.
//   Holds one blink-rate index per flash mode and runs a shared down-counter.
//   Drives the LED steady on, off, or blinking at the rate of the active flash mode.
//   Sits between the master FSM and the board LED; the master FSM's outputs connect 1:1.
// PARAMETERS
//   BASE_PERIOD  1_562_500  half-blink period in clk cycles at rate index 0
//   RATE_W       3          width of the rate index
//   RATE_MAX     6          largest legal rate index (slowest blink)
//   RATE_INIT    3          rate index loaded into both channels at reset
//   CNT_W        27         counter width; must hold (BASE_PERIOD << RATE_MAX) - 1
// PORTS
//   clk           in   1       system clock
//   reset_n       in   1       synchronous reset, active low
//   mode          in   3       master FSM state code
//   shift_left1   in   1       1-cycle pulse: slow FLASH1 (rate1 + 1)
//   shift_right1  in   1       1-cycle pulse: speed up FLASH1 (rate1 - 1)
//   shift_left2   in   1       same as shift_left1, for FLASH2
//   shift_right2  in   1       same as shift_right1, for FLASH2
//   led           out  1       registered LED drive
//   tick          out  1       1-cycle pulse on each blink toggle
//   rate1         out  RATE_W  current FLASH1 rate index
//   rate2         out  RATE_W  current FLASH2 rate index
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-low (reset_n).
//   - Reset: rate1 = rate2 = RATE_INIT; cnt = 0; led = 0; tick = 0; mode_q = OFF1.
//   - Mode codes: 0 OFF1, 2 ON, 3 OFF2, 4 FLASH1, 5 OFF3, 6 FLASH2.
//     Codes 1 and 7 are treated as OFF.
//   - Rate update, per channel, evaluated every cycle:
//     - left only: +1, saturating at RATE_MAX.
//     - right only: -1, saturating at 0.
//     - both asserted, or neither: hold.
//     - Rates are updated in every mode and are retained across mode changes.
//   - period(ch) = BASE_PERIOD << rate(ch). Compute at CNT_W bits; no truncation is allowed.
//   - mode_q registers mode. A mode change (mode != mode_q) takes priority over all counter activity.
//     - Entering FLASHx: led <= 1, cnt <= period(x) - 1, tick <= 0.
//     - Entering ON: led <= 1.
//     - Entering any OFF code: led <= 0, cnt <= 0.
//     - In all cases led changes on the cycle after mode changes (1-cycle latency).
//   - Steady FLASHx:
//     - cnt != 0: cnt decrements.
//     - cnt == 0: led toggles, tick = 1 for one cycle, cnt <= period(x) - 1.
//       period(x) is sampled at this reload; a rate change mid-count takes effect at the next reload.
//   - Steady ON: led = 1. Steady OFF: led = 0. In both, cnt holds 0 and tick = 0.
//   - reset_n low mid-blink: all state returns to reset values on the next edge; the blink phase is lost.
// CONFIGURATION
//   RATE_WRAP_EN defined: rate update wraps (RATE_MAX + 1 -> 0, 0 - 1 -> RATE_MAX).
//   RATE_WRAP_EN undefined: rate update saturates, as specified above.
// STRUCTURE
//   - Shared package/include lab3_defs: mode codes STATE_OFF1..STATE_FLASH2.
//     The master FSM uses the same file, so both blocks share one encoding.
//   - Sub-module rate_reg (RATE_W, RATE_MAX, RATE_INIT), instantiated twice.
//     Owns the saturate/wrap logic for one channel.
//   - Top level holds mode_q, the counter, the period mux and the led/tick registers.
// TESTING
//   Bench parameters: BASE_PERIOD=4, RATE_INIT=1, RATE_MAX=3, CNT_W=8.
//   1. reset_n low 2 cycles -> led=0, tick=0, rate1=rate2=1; mode=2 -> led=1 on the next cycle.
//   2. mode=4 held -> led=1 for 8 cycles, then tick pulse and led=0; toggles every 8 cycles.
//   3. FLASH1, 5 shift_left1 pulses -> rate1=3 (saturated), period 32 from the next reload;
//      with RATE_WRAP_EN, rate1 sequence is 2,3,0,1,2.
//   4. shift_left1 and shift_right1 asserted in the same cycle -> rate1 unchanged;
//      shift_right2 x2 -> rate2=0, FLASH2 period 4.
//   5. mode 4 -> 5 mid-count -> led=0 next cycle, no tick;
//      then mode=6 -> led=1, cnt=period(rate2)-1.
//   6. reset_n low during FLASH2 with led=0 -> led=0, cnt=0, rates=1; mode_q=OFF1 after release.

Source files
------------

// File: rtl/flash_rate_ctrl_pkg.sv
// flash_rate_ctrl_pkg: master-FSM state codes shared by the lab3 master FSM
// and flash_rate_ctrl, so both blocks decode one encoding.
// Codes 1 and 7 are unused by the FSM; the LED block treats them as OFF.
package flash_rate_ctrl_pkg;

  localparam logic [2:0] STATE_OFF1   = 3'd0;
  localparam logic [2:0] STATE_ON     = 3'd2;
  localparam logic [2:0] STATE_OFF2   = 3'd3;
  localparam logic [2:0] STATE_FLASH1 = 3'd4;
  localparam logic [2:0] STATE_OFF3   = 3'd5;
  localparam logic [2:0] STATE_FLASH2 = 3'd6;

  // One rate channel per flash mode.
  localparam int NUM_CH = 2;

  function automatic logic is_flash(input logic [2:0] m);
    return (m == STATE_FLASH1) || (m == STATE_FLASH2);
  endfunction

  // Channel that owns a flash mode: FLASH1 -> 0, FLASH2 -> 1.
  function automatic logic flash_ch(input logic [2:0] m);
    return (m == STATE_FLASH2);
  endfunction

endpackage

// File: rtl/flash_rate_ctrl_if.sv
// flash_rate_ctrl_if: master FSM <-> LED sequencer bus.
//   mode            FSM state code (master -> slave)
//   shift_left1/2   1-cycle pulse, slow the channel's blink (master -> slave)
//   shift_right1/2  1-cycle pulse, speed up the channel's blink (master -> slave)
//   led, tick       registered LED drive and toggle pulse (slave -> master)
//   rate1, rate2    current per-channel rate index (slave -> master)
interface flash_rate_ctrl_if #(
  parameter int RATE_W = 3
);
  logic [2:0]        mode;
  logic              shift_left1;
  logic              shift_right1;
  logic              shift_left2;
  logic              shift_right2;
  logic              led;
  logic              tick;
  logic [RATE_W-1:0] rate1;
  logic [RATE_W-1:0] rate2;

  modport master (
    output mode, shift_left1, shift_right1, shift_left2, shift_right2,
    input  led, tick, rate1, rate2
  );

  modport slave (
    input  mode, shift_left1, shift_right1, shift_left2, shift_right2,
    output led, tick, rate1, rate2
  );
endinterface

// File: rtl/flash_rate_ctrl_rate_reg.sv
// rate_reg: one blink-rate index register.
//   clk, reset_n  clock, synchronous active-low reset (loads RATE_INIT)
//   i_inc         +1 request (slower blink)
//   i_dec         -1 request (faster blink)
//   o_rate        current rate index, 0..RATE_MAX
// Both or neither request holds. Ends saturate by default; with RATE_WRAP_EN
// defined they wrap (RATE_MAX+1 -> 0, 0-1 -> RATE_MAX).
module rate_reg #(
  parameter int RATE_W    = 3,
  parameter int RATE_MAX  = 6,
  parameter int RATE_INIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_inc,
  input  logic              i_dec,
  output logic [RATE_W-1:0] o_rate
);
  localparam logic [RATE_W-1:0] MAXV = RATE_W'(RATE_MAX);
  localparam logic [RATE_W-1:0] ONE  = RATE_W'(1);

  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] w_lo_end;  // value after decrementing from 0
  logic [RATE_W-1:0] w_hi_end;  // value after incrementing from RATE_MAX

`ifdef RATE_WRAP_EN
  assign w_lo_end = MAXV;
  assign w_hi_end = '0;
`else
  assign w_lo_end = '0;
  assign w_hi_end = MAXV;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rate <= RATE_W'(RATE_INIT);
    end else if (i_inc && !i_dec) begin
      r_rate <= (r_rate >= MAXV) ? w_hi_end : r_rate + ONE;
    end else if (i_dec && !i_inc) begin
      r_rate <= (r_rate == '0) ? w_lo_end : r_rate - ONE;
    end
  end

  assign o_rate = r_rate;
endmodule

// File: rtl/flash_rate_ctrl.sv
// flash_rate_ctrl: blink timebase and LED sequencer behind the lab3 master FSM.
//   clk, reset_n  clock, synchronous active-low reset
//   bus (slave)   mode / shift pulses in; led, tick, rate1, rate2 out
// Two rate_reg channels (FLASH1, FLASH2) share one down-counter. A mode
// change reloads/clears the counter and sets the LED one cycle later; in a
// steady flash mode the LED toggles when the counter hits 0, reloading with
// (BASE_PERIOD << rate) - 1 sampled at that moment.
// Build option: RATE_WRAP_EN makes rate indices wrap instead of saturate.
module flash_rate_ctrl
  import flash_rate_ctrl_pkg::*;
#(
  parameter int BASE_PERIOD = 1_562_500,
  parameter int RATE_W      = 3,
  parameter int RATE_MAX    = 6,
  parameter int RATE_INIT   = 3,
  parameter int CNT_W       = 27
) (
  input  logic              clk,
  input  logic              reset_n,
  flash_rate_ctrl_if.slave  bus
);
  localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_CH-1:0]                w_inc;
  logic [NUM_CH-1:0]                w_dec;
  logic [NUM_CH-1:0][RATE_W-1:0]    w_rate;
  logic [NUM_CH-1:0][CNT_W-1:0]     w_reload;   // period(ch) - 1

  logic [2:0]       r_mode_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_led;
  logic             r_tick;

  assign w_inc = {bus.shift_left2,  bus.shift_left1};
  assign w_dec = {bus.shift_right2, bus.shift_right1};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rate_reg #(
      .RATE_W    (RATE_W),
      .RATE_MAX  (RATE_MAX),
      .RATE_INIT (RATE_INIT)
    ) u_rate (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_inc[ch]),
      .i_dec   (w_dec[ch]),
      .o_rate  (w_rate[ch])
    );
    // Shift is done at CNT_W bits; CNT_W is sized so the slowest period fits.
    assign w_reload[ch] = (BASE << w_rate[ch]) - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode_q <= STATE_OFF1;
      r_cnt    <= '0;
      r_led    <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_mode_q <= bus.mode;
      r_tick   <= 1'b0;
      if (bus.mode != r_mode_q) begin
        // Mode entry overrides any counter activity this cycle.
        if (is_flash(bus.mode)) begin
          r_led <= 1'b1;
          r_cnt <= w_reload[flash_ch(bus.mode)];
        end else begin
          r_led <= (bus.mode == STATE_ON);
          r_cnt <= '0;
        end
      end else if (is_flash(r_mode_q)) begin
        if (r_cnt == '0) begin
          r_led  <= ~r_led;
          r_tick <= 1'b1;
          r_cnt  <= w_reload[flash_ch(r_mode_q)];
        end else begin
          r_cnt <= r_cnt - CNT_ONE;
        end
      end else begin
        // Steady ON / any OFF code.
        r_led <= (r_mode_q == STATE_ON);
        r_cnt <= '0;
      end
    end
  end

  assign bus.led   = r_led;
  assign bus.tick  = r_tick;
  assign bus.rate1 = w_rate[0];
  assign bus.rate2 = w_rate[1];
endmodule

// File: tb/tb_flash_rate_ctrl.sv
// Directed bench for flash_rate_ctrl with BASE_PERIOD=4, RATE_INIT=1,
// RATE_MAX=3, CNT_W=8: periods are 8 at rate 1, 16 at rate 2, 32 at rate 3,
// 4 at rate 0. Expectations follow the RATE_WRAP_EN build option.
module tb_flash_rate_ctrl;
  import flash_rate_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  flash_rate_ctrl_if #(.RATE_W(3)) bus ();

  flash_rate_ctrl #(
    .BASE_PERIOD (4),
    .RATE_W      (3),
    .RATE_MAX    (3),
    .RATE_INIT   (1),
    .CNT_W       (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until tick is seen (bounded; 201 means it never came).
  task automatic wait_tick(output int n);
    n = 0;
    for (int i = 0; i < 201; i++) begin
      cyc();
      n++;
      if (bus.tick === 1'b1) break;
    end
  endtask

  task automatic pulse(input logic l1, r1, l2, r2);
    bus.shift_left1  = l1;
    bus.shift_right1 = r1;
    bus.shift_left2  = l2;
    bus.shift_right2 = r2;
    cyc();
    bus.shift_left1  = 1'b0;
    bus.shift_right1 = 1'b0;
    bus.shift_left2  = 1'b0;
    bus.shift_right2 = 1'b0;
  endtask

  int n;
  int nt;
`ifdef RATE_WRAP_EN
  int exp_r1 [5] = '{2, 3, 0, 1, 2};
  int exp_p1     = 16;
  int exp_r2a    = 0;
  int exp_r2b    = 3;
  int exp_p2     = 32;
`else
  int exp_r1 [5] = '{2, 3, 3, 3, 3};
  int exp_p1     = 32;
  int exp_r2a    = 0;
  int exp_r2b    = 0;
  int exp_p2     = 4;
`endif

  initial begin
    reset_n          = 1'b0;
    bus.mode         = STATE_OFF1;
    bus.shift_left1  = 1'b0;
    bus.shift_right1 = 1'b0;
    bus.shift_left2  = 1'b0;
    bus.shift_right2 = 1'b0;

    // 1. reset, then ON
    cyc(2);
    chk("rst_led",   bus.led,   0);
    chk("rst_tick",  bus.tick,  0);
    chk("rst_rate1", bus.rate1, 1);
    chk("rst_rate2", bus.rate2, 1);
    reset_n  = 1'b1;
    bus.mode = STATE_ON;
    cyc();
    chk("on_led", bus.led, 1);
    cyc(3);
    chk("on_steady_tick", bus.tick, 0);

    // 2. FLASH1 at rate 1: 8 cycles per toggle
    bus.mode = STATE_FLASH1;
    cyc();
    chk("f1_entry_led",  bus.led,  1);
    chk("f1_entry_tick", bus.tick, 0);
    wait_tick(n);
    chk("f1_first_period", n, 8);
    chk("f1_led_off", bus.led, 0);
    cyc();
    chk("f1_tick_1cyc", bus.tick, 0);
    wait_tick(n);
    chk("f1_second_period", n, 7);   // one cycle already spent above
    chk("f1_led_on", bus.led, 1);

    // 3. five shift_left1 pulses (counter runs 7 -> 2 meanwhile)
    for (int i = 0; i < 5; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sl1_rate1_%0d", i), bus.rate1, exp_r1[i]);
    end
    chk("rate2_untouched", bus.rate2, 1);
    wait_tick(n);
    chk("f1_old_period_tail", n, 3);  // reload here picks up the new rate
    wait_tick(n);
    chk("f1_new_period", n, exp_p1);
    chk("f1_led_after_new", bus.led, 1);

    // 4. both shifts on channel 1 -> hold; shift_right2 x2
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both_hold_rate1", bus.rate1, exp_r1[4]);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sr2_rate2_a", bus.rate2, exp_r2a);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sr2_rate2_b", bus.rate2, exp_r2b);

    // 5. FLASH1 -> OFF3 mid-count, then FLASH2
    chk("pre_off_led", bus.led, 1);
    bus.mode = STATE_OFF3;
    cyc();
    chk("off3_led",  bus.led,  0);
    chk("off3_tick", bus.tick, 0);
    nt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.tick === 1'b1) nt++;
    end
    chk("off3_no_ticks", nt, 0);
    chk("off3_led_hold", bus.led, 0);
    bus.mode = STATE_FLASH2;
    cyc();
    chk("f2_entry_led",  bus.led,  1);
    chk("f2_entry_tick", bus.tick, 0);
    wait_tick(n);
    chk("f2_period", n, exp_p2);
    chk("f2_led_off", bus.led, 0);

    // 6. reset during FLASH2 with led=0, mode stays FLASH2
    reset_n = 1'b0;
    cyc();
    chk("mid_rst_led",   bus.led,   0);
    chk("mid_rst_tick",  bus.tick,  0);
    chk("mid_rst_rate1", bus.rate1, 1);
    chk("mid_rst_rate2", bus.rate2, 1);
    reset_n = 1'b1;
    cyc();
    // mode_q back at OFF1, so FLASH2 is re-entered rather than continued.
    chk("post_rst_led",  bus.led,  1);
    chk("post_rst_tick", bus.tick, 0);
    wait_tick(n);
    chk("post_rst_period", n, 8);

    // Unused code 7 behaves as OFF.
    bus.mode = 3'd7;
    cyc();
    chk("code7_led", bus.led, 0);
    cyc(2);
    chk("code7_steady_led", bus.led, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
